wb_console: RTL and testbench
=============================

# wb_console

Wishbone responder for the 128-bit system bus: a memory-mapped byte console with a transmit FIFO and a receive FIFO. The CPU writes bytes into the TX FIFO, which drains over a valid/ready byte stream towards a UART or simulation sink. Bytes arriving on the RX stream are buffered and read back by the CPU. It sits beside the RAM on the same bus as the CPU's initiator port, decoded by a higher address bit outside this block.

## Interface
- `ADDR_WIDTH`, 16: number of `adr_i` bits decoded here. Bits above are ignored.
- `DEPTH`, 16: entries per FIFO. Must be a power of 2, at least 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `adr_i` in 32: byte address. Word index is `adr_i[ADDR_WIDTH-1:4]`.
- `dat_i` in 128: write data.
- `dat_o` out 128: read data.
- `we_i` in 1: write enable.
- `sel_i` in 16: byte lane selects.
- `stb_i` in 1: strobe.
- `cyc_i` in 1: cycle.
- `ack_o` out 1: transfer acknowledge.
- `err_o` out 1: transfer error.
- `tx_data` out 8: byte to sink.
- `tx_valid` out 1: TX FIFO not empty.
- `tx_ready` in 1: sink accepts the byte.
- `rx_data` in 8: byte from source.
- `rx_valid` in 1: source has a byte.
- `rx_ready` out 1: RX FIFO not full.
- `irq` out 1: level interrupt.

## Operation
- Register map, by word index:
  - **0 DATA.**
    - Write with `sel_i[0]=1` pushes `dat_i[7:0]` to the TX FIFO. Write with `sel_i[0]=0` does nothing.
    - Read returns `{119'b0, rx_nonempty, rx_byte}`. It pops the RX FIFO if the FIFO is non-empty. If the FIFO is empty, it returns 0.
  - **1 STATUS.**
    - Read fields: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_overflow (sticky), [5] rx_overflow (sticky), [15:8] tx_count, [23:16] rx_count. All other bits are 0.
    - Write with `sel_i[0]=1`: a 1 in `dat_i[4]` or `dat_i[5]` clears the corresponding sticky bit. All other bits are ignored.
  - **2 CTRL.** Read/write. [0] rx_irq_en, [1] tx_empty_irq_en. Bits are writable per `sel_i[0]`. All other bits read 0.
  - **Index ≥3.** Respond with `err_o` instead of `ack_o`. No side effects. `dat_o`=0.
- Write to DATA when TX is full: the byte is dropped, the transfer is still acked, and tx_overflow is set.
- RX stream: a byte is pushed when `rx_valid & rx_ready`. `rx_ready` = !rx_full, so rx_overflow is set only if the source violates this. It is kept as a guard.
- TX stream: a byte is popped when `tx_valid & tx_ready`. `tx_data` = FIFO head, stable while `tx_valid` is high and `tx_ready` is low.
- `irq` is registered: `(rx_irq_en & !rx_empty) | (tx_empty_irq_en & tx_empty)`.

## Timing
- Responder FSM states: IDLE, RESP.
  - IDLE → RESP on `stb_i & cyc_i`. Address, `we_i`, `sel_i` and `dat_i` are sampled on that edge.
  - RESP drives `ack_o` or `err_o` high for exactly 1 cycle, with `dat_o` valid, then returns to IDLE.
  - No pipelining: a held `stb_i` produces a new transfer every 2 cycles.
- Side effects of a transfer (push, pop, clear, CTRL write) take effect on the IDLE→RESP edge. Status read in the same transfer reflects the state before that edge.
- If `cyc_i` drops while in RESP, the ack is still driven. The side effect has already occurred.
- Full/empty and count flags use the registered state at the start of the cycle:
  - A push is accepted iff not full, even if a pop occurs in the same cycle.
  - A pop is allowed iff not empty.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Count = wptr − rptr modulo 2·DEPTH, range 0..DEPTH.
- Reset values:
  - `ack_o`, `err_o`, `dat_o`, `irq` = 0.
  - `tx_valid` = 0, `rx_ready` = 1 on the first cycle after reset.
  - FIFOs empty, CTRL = 0, sticky bits = 0, FSM in IDLE.
- Reset during RESP aborts the ack. The initiator must retry.

## Structure
- Shared package `console_pkg`:
  - word-index constants `CON_DATA=0`, `CON_STATUS=1`, `CON_CTRL=2`;
  - STATUS bit positions;
  - CTRL bit positions.
- One sub-module, `sync_fifo`, parameterized by WIDTH and DEPTH.
  - Ports: push/pop/din/dout/full/empty/count.
  - Registered pointers with combinational head.
  - Instantiated twice: TX and RX.
- Top level holds the Wishbone FSM, register decode, sticky bits, CTRL and irq.

## Test plan
- **TX drain:** write DATA=0x41, 0x42 with `sel_i=16'h0001`, `tx_ready=1` → each ack arrives 1 cycle after its strobe. `tx_data` shows 0x41 then 0x42 on consecutive handshakes. `tx_empty=1` afterwards.
- **Overflow:** `tx_ready=0`, write DEPTH+1 bytes → STATUS reads tx_full=1, tx_count=DEPTH, tx_overflow=1. Writing STATUS with `dat_i[4]=1` clears only the overflow bit.
- **RX read:** drive 0x5A on RX with `rx_valid` → DATA read returns 0x15A. A second read returns 0 with no pop. `rx_ready` stays 1 throughout.
- **Error decode:** read word index 3, then write word index 7 → `err_o` pulses and `ack_o` stays low. No FIFO or CTRL change.
- **Interrupt:** CTRL=0x1, push 1 RX byte → `irq` rises within 2 cycles. Reading DATA drops `irq` 1 cycle after the ack.
- **Reset and concurrency:** assert `rst` during RESP → no ack, FIFOs empty, `irq`=0. Then a concurrent TX push/pop at count 3 keeps count 3.

Source files
------------

// File: rtl/console_pkg.sv
// Register map constants and responder state type shared by the console
// responder and its bench.
package console_pkg;

  localparam int unsigned CON_DATA   = 32'd0;
  localparam int unsigned CON_STATUS = 32'd1;
  localparam int unsigned CON_CTRL   = 32'd2;

  localparam int unsigned ST_TX_FULL    = 32'd0;
  localparam int unsigned ST_TX_EMPTY   = 32'd1;
  localparam int unsigned ST_RX_FULL    = 32'd2;
  localparam int unsigned ST_RX_EMPTY   = 32'd3;
  localparam int unsigned ST_TX_OVF     = 32'd4;
  localparam int unsigned ST_RX_OVF     = 32'd5;
  localparam int unsigned ST_TX_CNT_LSB = 32'd8;
  localparam int unsigned ST_RX_CNT_LSB = 32'd16;

  localparam int unsigned CTRL_RX_IRQ_EN       = 32'd0;
  localparam int unsigned CTRL_TX_EMPTY_IRQ_EN = 32'd1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Full when the pointers differ only in the wrap bit.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count     = wptr_q - rptr_q;
  assign dout      = mem_q[rptr_q[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_console.sv
// Wishbone byte console: TX/RX byte FIFOs behind a three-register map with a
// non-pipelined two-state responder and a level interrupt.
module wb_console
  import console_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  adr_i,
  input  logic [127:0] dat_i,
  output logic [127:0] dat_o,
  input  logic         we_i,
  input  logic [15:0]  sel_i,
  input  logic         stb_i,
  input  logic         cyc_i,
  output logic         ack_o,
  output logic         err_o,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e      state_q, state_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [127:0]   dat_q, dat_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic           tx_ovf_q, tx_ovf_d;
  logic           rx_ovf_q, rx_ovf_d;
  logic           irq_q, irq_d;

  logic [31:0]    widx_s;
  logic [127:0]   status_s;
  logic           tx_push_s, tx_pop_s, rx_pop_s;
  logic           clr_tx_ovf_s, clr_rx_ovf_s;
  logic           tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [7:0]     tx_head_s, rx_head_s;
  logic [CW-1:0]  tx_count_s, rx_count_s;
  logic           unused_s;

  assign unused_s = ^{adr_i[31:ADDR_WIDTH], adr_i[3:0], dat_i[127:8], sel_i[15:1]};

  assign tx_pop_s = tx_ready && !tx_empty_s;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (dat_i[7:0]),
    .dout  (tx_head_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop_s),
    .din   (rx_data),
    .dout  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  // Status word is built from pre-edge state so a read sees state before its own side effects.
  always_comb begin
    status_s                            = '0;
    status_s[ST_TX_FULL]                = tx_full_s;
    status_s[ST_TX_EMPTY]               = tx_empty_s;
    status_s[ST_RX_FULL]                = rx_full_s;
    status_s[ST_RX_EMPTY]               = rx_empty_s;
    status_s[ST_TX_OVF]                 = tx_ovf_q;
    status_s[ST_RX_OVF]                 = rx_ovf_q;
    status_s[ST_TX_CNT_LSB +: 8]        = 8'(tx_count_s);
    status_s[ST_RX_CNT_LSB +: 8]        = 8'(rx_count_s);
    widx_s                              = '0;
    widx_s[ADDR_WIDTH-5:0]              = adr_i[ADDR_WIDTH-1:4];
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    dat_d        = '0;
    ctrl_d       = ctrl_q;
    tx_push_s    = 1'b0;
    rx_pop_s     = 1'b0;
    clr_tx_ovf_s = 1'b0;
    clr_rx_ovf_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stb_i && cyc_i) begin
          state_d = S_RESP;
          case (widx_s)
            CON_DATA: begin
              ack_d = 1'b1;
              if (we_i) begin
                tx_push_s = sel_i[0];
              end else begin
                rx_pop_s = !rx_empty_s;
                dat_d    = rx_empty_s ? 128'd0 : {119'd0, 1'b1, rx_head_s};
              end
            end
            CON_STATUS: begin
              ack_d = 1'b1;
              if (we_i) begin
                clr_tx_ovf_s = sel_i[0] && dat_i[ST_TX_OVF];
                clr_rx_ovf_s = sel_i[0] && dat_i[ST_RX_OVF];
              end else begin
                dat_d = status_s;
              end
            end
            CON_CTRL: begin
              ack_d = 1'b1;
              if (we_i) begin
                ctrl_d = sel_i[0] ? dat_i[1:0] : ctrl_q;
              end else begin
                dat_d = {126'd0, ctrl_q};
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky overflow: a set on the same edge as a clear wins.
  always_comb begin
    tx_ovf_d = (tx_ovf_q && !clr_tx_ovf_s) || (tx_push_s && tx_full_s);
    rx_ovf_d = (rx_ovf_q && !clr_rx_ovf_s) || (rx_valid && rx_full_s);
    irq_d    = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty_s) ||
               (ctrl_q[CTRL_TX_EMPTY_IRQ_EN] && tx_empty_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      ctrl_q   <= 2'b00;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign dat_o    = dat_q;
  assign irq      = irq_q;
  assign tx_data  = tx_head_s;
  assign tx_valid = !tx_empty_s;
  assign rx_ready = !rx_full_s;

endmodule

// File: tb/tb_wb_console.sv
// Randomized and directed bench for wb_console against a queue-based
// transaction model of the register map and byte streams.
module tb_wb_console;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  adr_i;
  logic [127:0] dat_i;
  logic [127:0] dat_o;
  logic         we_i;
  logic [15:0]  sel_i;
  logic         stb_i;
  logic         cyc_i;
  logic         ack_o;
  logic         err_o;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         irq;

  always #5 clk = ~clk;

  wb_console #(.ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .ack_o(ack_o), .err_o(err_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: FIFO contents as queues plus the visible registers.
  logic [7:0]   txq[$];
  logic [7:0]   rxq[$];
  logic         m_txo, m_rxo, m_busy, m_ack, m_err, m_irq;
  logic [1:0]   m_ctrl;
  logic [127:0] m_dat;
  logic         chk_en = 1'b0;

  logic         cap_ack, cap_err;
  logic [127:0] cap_dat;
  logic [7:0]   cap_txd;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    cap_ack = ack_o;
    cap_err = err_o;
    cap_dat = dat_o;
    cap_txd = tx_data;
    if (chk_en) begin
      check_eq("ack", ack_o, m_ack);
      check_eq("err", err_o, m_err);
      check_eq("irq", irq, m_irq);
      if (m_ack || m_err) check_eq("dat", dat_o, m_dat);
      check_eq("tx_valid", tx_valid, txq.size() > 0);
      if (txq.size() > 0) check_eq("tx_data", tx_data, txq[0]);
      check_eq("rx_ready", rx_ready, rxq.size() < DEPTH);
    end
  endtask

  // Apply one clock edge worth of behaviour to the model, using the inputs now on the pins.
  task automatic model_edge();
    int ts;
    int rs;
    int idx;
    logic push_tx;
    logic pop_rx;
    logic [127:0] nd;
    logic na;
    logic ne;
    ts = txq.size();
    rs = rxq.size();
    push_tx = 1'b0;
    pop_rx = 1'b0;
    nd = '0;
    na = 1'b0;
    ne = 1'b0;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_txo = 1'b0; m_rxo = 1'b0; m_ctrl = 2'b00; m_busy = 1'b0;
      m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_irq = 1'b0;
      return;
    end
    m_irq = (m_ctrl[0] && rs > 0) || (m_ctrl[1] && ts == 0);
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (stb_i && cyc_i) begin
      m_busy = 1'b1;
      idx = int'((adr_i >> 4) & 32'h0000_0FFF);
      if (idx == 0) begin
        na = 1'b1;
        if (we_i) begin
          if (sel_i[0]) begin
            if (ts < DEPTH) push_tx = 1'b1;
            else m_txo = 1'b1;
          end
        end else if (rs > 0) begin
          nd = 128'h100 | 128'(rxq[0]);
          pop_rx = 1'b1;
        end
      end else if (idx == 1) begin
        na = 1'b1;
        if (we_i) begin
          if (sel_i[0] && dat_i[4]) m_txo = 1'b0;
          if (sel_i[0] && dat_i[5]) m_rxo = 1'b0;
        end else begin
          nd = 128'(ts == DEPTH) | (128'(ts == 0) << 1) | (128'(rs == DEPTH) << 2) |
               (128'(rs == 0) << 3) | (128'(m_txo) << 4) | (128'(m_rxo) << 5) |
               (128'(ts) << 8) | (128'(rs) << 16);
        end
      end else if (idx == 2) begin
        na = 1'b1;
        if (we_i) begin
          if (sel_i[0]) m_ctrl = dat_i[1:0];
        end else begin
          nd = 128'(m_ctrl);
        end
      end else begin
        ne = 1'b1;
      end
    end
    m_ack = na;
    m_err = ne;
    m_dat = nd;
    if (pop_rx) void'(rxq.pop_front());
    if (tx_ready && ts > 0) void'(txq.pop_front());
    if (push_tx) txq.push_back(dat_i[7:0]);
    if (rx_valid) begin
      if (rs < DEPTH) rxq.push_back(rx_data);
      else m_rxo = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input int idx, input logic [127:0] d, input logic [15:0] s);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = w; adr_i = 32'(idx) << 4; dat_i = d; sel_i = s;
    tick();
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; dat_i = '0; sel_i = 16'h0000;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nacks;
    rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = 16'h0000;
    stb_i = 1'b0; cyc_i = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_ack", ack_o, 1'b0);
    check_eq("rst_dat", dat_o, 128'd0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_rx_ready", rx_ready, 1'b1);

    // TX drain
    tx_ready = 1'b1;
    xfer(1'b1, 0, 128'h41, 16'h0001);
    check_eq("drain_ack0", cap_ack, 1'b1);
    check_eq("drain_txd0", cap_txd, 8'h41);
    xfer(1'b1, 0, 128'h42, 16'h0001);
    check_eq("drain_txd1", cap_txd, 8'h42);
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("drain_tx_empty", cap_dat[1], 1'b1);

    // Overflow
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) xfer(1'b1, 0, 128'(i + 1), 16'h0001);
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("ovf_full", cap_dat[0], 1'b1);
    check_eq("ovf_count", cap_dat[15:8], 8'(DEPTH));
    check_eq("ovf_sticky", cap_dat[4], 1'b1);
    xfer(1'b1, 1, 128'h10, 16'h0001);
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("ovf_clr_bit", cap_dat[4], 1'b0);
    check_eq("ovf_clr_full", cap_dat[0], 1'b1);
    check_eq("ovf_clr_cnt", cap_dat[15:8], 8'(DEPTH));
    tx_ready = 1'b1;
    idle(DEPTH + 2);

    // RX read
    rx_valid = 1'b1; rx_data = 8'h5A;
    tick();
    rx_valid = 1'b0;
    xfer(1'b0, 0, 128'd0, 16'hFFFF);
    check_eq("rx_read", cap_dat, 128'h15A);
    xfer(1'b0, 0, 128'd0, 16'hFFFF);
    check_eq("rx_read_empty", cap_dat, 128'd0);

    // Error decode
    xfer(1'b0, 3, 128'd0, 16'hFFFF);
    check_eq("err3_err", cap_err, 1'b1);
    check_eq("err3_ack", cap_ack, 1'b0);
    xfer(1'b1, 7, '1, 16'hFFFF);
    check_eq("err7_err", cap_err, 1'b1);
    check_eq("err7_ack", cap_ack, 1'b0);
    xfer(1'b0, 2, 128'd0, 16'hFFFF);
    check_eq("err_ctrl_kept", cap_dat, 128'd0);
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("err_status_kept", cap_dat, 128'h0A);

    // Interrupt
    xfer(1'b1, 2, 128'h1, 16'h0001);
    rx_valid = 1'b1; rx_data = 8'h33;
    tick();
    rx_valid = 1'b0;
    tick();
    check_eq("irq_rise", irq, 1'b1);
    xfer(1'b0, 0, 128'd0, 16'hFFFF);
    check_eq("irq_read", cap_dat, 128'h133);
    check_eq("irq_fall", irq, 1'b0);

    // Held strobe: one transfer every two cycles
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h10; sel_i = 16'hFFFF;
    nacks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nacks += int'(cap_ack);
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    check_eq("held_acks", 128'(nacks), 128'd2);
    tick();

    // Reset on the accepting edge, with state to discard
    tx_ready = 1'b0;
    xfer(1'b1, 0, 128'h77, 16'h0001);
    rx_valid = 1'b1; rx_data = 8'h12;
    tick();
    rx_valid = 1'b0;
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h10; rst = 1'b1;
    tick();
    rst = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    tick();
    check_eq("rstx_ack", cap_ack, 1'b0);
    check_eq("rstx_irq", irq, 1'b0);
    check_eq("rstx_tx_valid", tx_valid, 1'b0);
    check_eq("rstx_rx_ready", rx_ready, 1'b1);
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("rstx_status", cap_dat, 128'h0A);

    // Concurrent push and pop at count 3
    for (int i = 0; i < 3; i++) xfer(1'b1, 0, 128'(8'hA0 + i), 16'h0001);
    stb_i = 1'b1; cyc_i = 1'b1; we_i = 1'b1; adr_i = 32'h0; dat_i = 128'h99; sel_i = 16'h0001;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    tick();
    xfer(1'b0, 1, 128'd0, 16'hFFFF);
    check_eq("conc_count", cap_dat[15:8], 8'd3);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      stb_i = ($urandom_range(0, 2) != 0);
      cyc_i = stb_i ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      we_i = 1'($urandom_range(0, 1));
      adr_i = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 4) | ($urandom() & 32'hF);
      if ($urandom_range(0, 15) == 0) adr_i[15:4] = 12'($urandom());
      dat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel_i = 16'($urandom());
      if ($urandom_range(0, 3) != 0) sel_i[0] = 1'b1;
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data = 8'($urandom());
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    idle(DEPTH + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
